// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single SRAM-like external memory port between the instruction
// fetch side (IF) and the data access side (DM) of the MiniMIPS32 core.
// A winning request is latched into registered bus fields, then driven
// through an address phase (ADDR) and a data phase (DATA). Read data is
// returned to the owning requester together with a one-cycle done pulse.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   -> contended grants alternate using a
//                                    last_grant register (reset = IF, so
//                                    the first contended grant goes to DM)
//                       undefined -> fixed priority, DM beats IF
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request (level, held until if_done)
//   if_rdata/if_done         fetched word + one-cycle completion pulse
//   dm_req/dm_we/dm_sel/
//   dm_addr/dm_wdata         data request (level, held until dm_done)
//   dm_rdata/dm_done         load data + one-cycle completion pulse
//   flush                    exception/eret flush, discards in-flight fetch
//   stall_req                pipeline stall while any request is pending
//   bus_req/bus_wr/bus_sel/
//   bus_addr/bus_wdata       registered memory bus request fields
//   bus_addr_ok/bus_data_ok/
//   bus_rdata                memory bus responses
//   o_dbg_state              current FSM state (IDLE=0, ADDR=1, DATA=2)
//
// Bus handshake: bus_req is raised for the whole address phase with all
// request fields stable and is only dropped after bus_addr_ok has been
// sampled high (never withdrawn early, not even on flush). The data phase
// then waits for bus_data_ok; bus_addr_ok and bus_data_ok high together in
// the address phase finish the whole transaction in that cycle.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_sel,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  input  logic              flush,
  output logic              stall_req,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner;
  logic              r_discard;
  logic              r_bus_req;
  logic              r_bus_wr;
  logic [3:0]        r_bus_sel;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_done;
  logic              r_dm_done;

  logic w_if_elig;
  logic w_dm_elig;
  logic w_grant_dm;
  logic w_grant_if;
  logic w_complete;

  // A requester whose done is high this cycle is still holding its req
  // (it only sees done now), so it must not be granted again. Flush in
  // IDLE also blocks a fetch grant for that cycle.
  assign w_if_elig = if_req & ~r_if_done & ~flush;
  assign w_dm_elig = dm_req & ~r_dm_done;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  // On contention favour whoever was not granted last.
  assign w_grant_dm = w_dm_elig & (~w_if_elig | (r_last_grant == OWN_IF));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= OWN_IF;
    end else if (r_state == ST_IDLE && (w_grant_dm || w_grant_if)) begin
      r_last_grant <= w_grant_dm ? OWN_DM : OWN_IF;
    end
  end
`else
  assign w_grant_dm = w_dm_elig;
`endif

  assign w_grant_if = w_if_elig & ~w_grant_dm;

  // Transaction finishes on data_ok in DATA, or on addr_ok+data_ok together
  // while still in ADDR.
  assign w_complete = ((r_state == ST_DATA) && bus_data_ok) ||
                      ((r_state == ST_ADDR) && bus_addr_ok && bus_data_ok);

  // ---------------- FSM state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_dm || w_grant_if) begin
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus_addr_ok) begin
          w_state_nxt = bus_data_ok ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus_data_ok) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- bus fields, owner, results ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= OWN_IF;
      r_discard   <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_bus_sel   <= 4'b0000;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_done   <= 1'b0;
      r_dm_done   <= 1'b0;
    end else begin
      r_if_done <= 1'b0;
      r_dm_done <= 1'b0;

      if (r_state == ST_IDLE) begin
        r_discard <= 1'b0;
        if (w_grant_dm) begin
          r_owner     <= OWN_DM;
          r_bus_req   <= 1'b1;
          r_bus_wr    <= dm_we;
          r_bus_sel   <= dm_sel;
          r_bus_addr  <= dm_addr;
          r_bus_wdata <= dm_wdata;
        end else if (w_grant_if) begin
          r_owner     <= OWN_IF;
          r_bus_req   <= 1'b1;
          r_bus_wr    <= 1'b0;
          r_bus_sel   <= 4'b1111;
          r_bus_addr  <= if_addr;
          r_bus_wdata <= '0;
        end
      end

      // Request fields are only meaningful during ADDR; bus_addr is kept.
      if (r_state == ST_ADDR && bus_addr_ok) begin
        r_bus_req   <= 1'b0;
        r_bus_wr    <= 1'b0;
        r_bus_sel   <= 4'b0000;
        r_bus_wdata <= '0;
      end

      // A flushed fetch still runs to completion on the bus; only its
      // result is dropped.
      if ((r_state != ST_IDLE) && (r_owner == OWN_IF) && flush) begin
        r_discard <= 1'b1;
      end

      if (w_complete) begin
        r_discard <= 1'b0;
        if (r_owner == OWN_DM) begin
          r_dm_rdata <= bus_rdata;
          r_dm_done  <= 1'b1;
        end else if (!(r_discard || flush)) begin
          r_if_rdata <= bus_rdata;
          r_if_done  <= 1'b1;
        end
      end
    end
  end

  assign if_rdata    = r_if_rdata;
  assign if_done     = r_if_done;
  assign dm_rdata    = r_dm_rdata;
  assign dm_done     = r_dm_done;
  assign bus_req     = r_bus_req;
  assign bus_wr      = r_bus_wr;
  assign bus_sel     = r_bus_sel;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign stall_req   = (dm_req & ~r_dm_done) | (if_req & ~r_if_done);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed, cycle-by-cycle bench for mem_port_arbiter. Inputs change 1 ns
// after the rising edge, outputs are sampled 3 ns after it. Expected read
// data is pushed into exp_q when the bus returns it and popped at the done
// pulse.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_sel;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        flush;
  logic        stall_req;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_done    (if_done),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_sel     (dm_sel),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_done    (dm_done),
    .flush      (flush),
    .stall_req  (stall_req),
    .bus_req    (bus_req),
    .bus_wr     (bus_wr),
    .bus_sel    (bus_sel),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok),
    .bus_rdata  (bus_rdata),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic        own_dm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [1:0] exp);
    n_cmp++;
    assert (dbg_state === exp) else begin
      n_err++;
      $error("FAIL %s: observed state %0d expected state %0d", tag, dbg_state, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed %h expected <nothing queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_sel = 4'h0; dm_addr = '0; dm_wdata = '0; flush = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;

    // Reset values
    cyc(); cyc(); settle();
    chk_st("rst_state", 2'd0);
    chk1("rst_bus_req", bus_req, 1'b0);
    chk1("rst_bus_wr", bus_wr, 1'b0);
    chk("rst_bus_sel", {28'd0, bus_sel}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk1("rst_if_done", if_done, 1'b0);
    chk1("rst_dm_done", dm_done, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk1("rst_stall", stall_req, 1'b0);

    // Single fetch, minimum latency
    cyc(); rst = 1'b0; if_req = 1'b1; if_addr = 32'hBFC0_0000; settle();
    chk1("f1_stall_c0", stall_req, 1'b1);
    chk1("f1_bus_req_c0", bus_req, 1'b0);
    cyc(); bus_addr_ok = 1'b1; settle();
    chk_st("f1_state_c1", 2'd1);
    chk1("f1_bus_req_c1", bus_req, 1'b1);
    chk("f1_bus_addr", bus_addr, 32'hBFC0_0000);
    chk("f1_bus_sel", {28'd0, bus_sel}, 32'hF);
    chk1("f1_bus_wr", bus_wr, 1'b0);
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3C08_BFC0;
    exp_q.push_back(32'h3C08_BFC0); settle();
    chk_st("f1_state_c2", 2'd2);
    chk1("f1_bus_req_c2", bus_req, 1'b0);
    chk("f1_bus_sel_c2", {28'd0, bus_sel}, 32'h0);
    cyc(); bus_data_ok = 1'b0; bus_rdata = '0; settle();
    chk1("f1_if_done_c3", if_done, 1'b1);
    chk_pop("f1_if_rdata", if_rdata);
    chk1("f1_stall_c3", stall_req, 1'b0);
    chk_st("f1_state_c3", 2'd0);
    cyc(); if_req = 1'b0; settle();
    chk1("f1_no_regrant", bus_req, 1'b0);
    chk1("f1_if_done_c4", if_done, 1'b0);
    chk1("f1_stall_c4", stall_req, 1'b0);

    // Contention under priority: DM store first with addr_ok+data_ok together
    cyc(); if_req = 1'b1; if_addr = 32'hBFC0_0004; dm_req = 1'b1; dm_we = 1'b1;
    dm_sel = 4'b0011; dm_addr = 32'h8000_0010; dm_wdata = 32'h1234_5678; settle();
    chk1("c_stall_c0", stall_req, 1'b1);
    cyc(); bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h0;
    exp_q.push_back(32'h0); settle();
    chk1("c_bus_req_dm", bus_req, 1'b1);
    chk1("c_bus_wr_dm", bus_wr, 1'b1);
    chk("c_bus_sel_dm", {28'd0, bus_sel}, 32'h3);
    chk("c_bus_addr_dm", bus_addr, 32'h8000_0010);
    chk("c_bus_wdata_dm", bus_wdata, 32'h1234_5678);
    chk1("c_stall_c1", stall_req, 1'b1);
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b0; dm_req = 1'b0; dm_we = 1'b0; settle();
    chk1("c_dm_done", dm_done, 1'b1);
    chk_pop("c_dm_rdata", dm_rdata);
    chk1("c_gap_bus_req", bus_req, 1'b0);
    chk1("c_if_done_c2", if_done, 1'b0);
    chk1("c_stall_c2", stall_req, 1'b1);
    cyc(); bus_addr_ok = 1'b1; settle();
    chk1("c_bus_req_if", bus_req, 1'b1);
    chk("c_bus_addr_if", bus_addr, 32'hBFC0_0004);
    chk1("c_bus_wr_if", bus_wr, 1'b0);
    chk("c_bus_sel_if", {28'd0, bus_sel}, 32'hF);
    chk("c_bus_wdata_if", bus_wdata, 32'h0);
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2408_0001;
    exp_q.push_back(32'h2408_0001); settle();
    chk1("c_stall_c4", stall_req, 1'b1);
    cyc(); bus_data_ok = 1'b0; settle();
    chk1("c_if_done", if_done, 1'b1);
    chk_pop("c_if_rdata", if_rdata);
    chk1("c_stall_c5", stall_req, 1'b0);
    cyc(); if_req = 1'b0; settle();
    chk_st("c_state_end", 2'd0);

    // Flush while fetch is in DATA: result discarded, bus completes
    cyc(); if_req = 1'b1; if_addr = 32'hBFC0_0008; settle();
    cyc(); bus_addr_ok = 1'b1; settle();
    chk("fl_bus_addr", bus_addr, 32'hBFC0_0008);
    cyc(); bus_addr_ok = 1'b0; flush = 1'b1; settle();
    chk_st("fl_state_data", 2'd2);
    cyc(); flush = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hAAAA_AAAA; settle();
    chk1("fl_bus_req_data", bus_req, 1'b0);
    cyc(); bus_data_ok = 1'b0; if_req = 1'b0; settle();
    chk1("fl_no_if_done", if_done, 1'b0);
    chk("fl_if_rdata_kept", if_rdata, 32'h2408_0001);
    chk_st("fl_state_idle", 2'd0);

    // Flush in IDLE suppresses the fetch grant, then wait states
    cyc(); if_req = 1'b1; if_addr = 32'hBFC0_000C; flush = 1'b1; settle();
    chk1("ws_stall", stall_req, 1'b1);
    cyc(); flush = 1'b0; settle();
    chk_st("ws_suppressed_state", 2'd0);
    chk1("ws_suppressed_req", bus_req, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(); bus_addr_ok = (i == 3); settle();
      chk_st("ws_addr_state", 2'd1);
      chk1("ws_addr_bus_req", bus_req, 1'b1);
      chk("ws_addr_bus_addr", bus_addr, 32'hBFC0_000C);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(); bus_addr_ok = 1'b0; bus_data_ok = (i == 3);
      if (i == 3) begin
        bus_rdata = 32'h8C09_0000;
        exp_q.push_back(32'h8C09_0000);
      end
      settle();
      chk_st("ws_data_state", 2'd2);
      chk1("ws_data_no_done", if_done, 1'b0);
    end
    cyc(); bus_data_ok = 1'b0; if_req = 1'b0; settle();
    chk1("ws_if_done", if_done, 1'b1);
    chk_pop("ws_if_rdata", if_rdata);
    cyc(); settle();
    chk1("ws_if_done_once", if_done, 1'b0);

    // Reset in the middle of a DM load
    cyc(); dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h8000_0020; settle();
    cyc(); bus_addr_ok = 1'b1; settle();
    chk1("rm_bus_wr", bus_wr, 1'b0);
    chk("rm_bus_addr", bus_addr, 32'h8000_0020);
    cyc(); bus_addr_ok = 1'b0; rst = 1'b1; settle();
    chk_st("rm_state_data", 2'd2);
    cyc(); rst = 1'b0; dm_req = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h5555_5555; settle();
    chk_st("rm_state_idle", 2'd0);
    chk1("rm_bus_req", bus_req, 1'b0);
    chk("rm_bus_addr_clr", bus_addr, 32'h0);
    chk1("rm_dm_done", dm_done, 1'b0);
    chk("rm_if_rdata_clr", if_rdata, 32'h0);
    cyc(); bus_data_ok = 1'b0; settle();
    chk1("rm_late_dm_done", dm_done, 1'b0);
    chk("rm_late_dm_rdata", dm_rdata, 32'h0);
    chk1("rm_late_bus_req", bus_req, 1'b0);

    // Plain DM load
    cyc(); dm_req = 1'b1; dm_addr = 32'h8000_0024; settle();
    cyc(); bus_addr_ok = 1'b1; settle();
    chk("ld_bus_addr", bus_addr, 32'h8000_0024);
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1357_2468;
    exp_q.push_back(32'h1357_2468); settle();
    cyc(); bus_data_ok = 1'b0; dm_req = 1'b0; settle();
    chk1("ld_dm_done", dm_done, 1'b1);
    chk_pop("ld_dm_rdata", dm_rdata);
    chk1("ld_if_done", if_done, 1'b0);

    // Continuous requests from both sides; last grant was DM
`ifdef ARB_ROUND_ROBIN_EN
    own_dm = 1'b0;
`else
    own_dm = 1'b1;
`endif
    cyc(); if_req = 1'b1; if_addr = 32'hBFC0_0010; dm_req = 1'b1; dm_we = 1'b1;
    dm_sel = 4'hC; dm_addr = 32'h8000_0030; dm_wdata = 32'hCAFE_F00D; settle();
    chk1("alt_stall_c0", stall_req, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(); bus_addr_ok = 1'b1; settle();
      chk("alt_bus_addr", bus_addr, own_dm ? 32'h8000_0030 : 32'hBFC0_0010);
      chk1("alt_bus_wr", bus_wr, own_dm);
      cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1000_0000 + 32'(k);
      exp_q.push_back(32'h1000_0000 + 32'(k)); settle();
      cyc(); bus_data_ok = 1'b0;
      if (k == 3) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
      settle();
      chk1("alt_dm_done", dm_done, own_dm);
      chk1("alt_if_done", if_done, !own_dm);
      chk_pop("alt_rdata", own_dm ? dm_rdata : if_rdata);
      if (k < 3) chk1("alt_stall", stall_req, 1'b1);
      own_dm = !own_dm;
    end
    cyc(); settle();
    chk1("alt_end_bus_req", bus_req, 1'b0);
    chk1("alt_end_stall", stall_req, 1'b0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
